pe_csc_stream_loader: RTL and testbench

//  Upstream feeder of one PE. Sequences the CSC-compressed iact (address + data) and weight (address + data)

---
 rtl/pe_csc_stream_loader_pkg.sv | 28 ++
 rtl/pe_csc_stream_loader_if.sv | 44 ++++
 rtl/pe_csc_stream_loader_csc_rd_stream.sv | 40 ++++
 rtl/pe_csc_stream_loader.sv | 98 +++++++++
 tb/tb_pe_csc_stream_loader.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pe_csc_stream_loader_pkg.sv
// Shared types for the PE CSC stream loader: FSM states, stream ids, PE field widths
// and the helper that picks the next non-empty stream.
package pe_csc_stream_loader_pkg;

  localparam int IA_ADDR_W = 8;
  localparam int IA_DATA_W = 13;
  localparam int W_ADDR_W  = 7;
  localparam int W_DATA_W  = 12;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR_W, S_CLR_I,
    S_IA_ADDR, S_IA_DATA, S_W_ADDR, S_W_DATA,
    S_DRAIN, S_WAIT_FIN, S_LOAD, S_WAIT_CAL
  } state_t;

  typedef enum logic [1:0] {IA_ADDR, IA_DATA, W_ADDR, W_DATA} stream_id_t;

  // First stream at or after index 'first' with a non-zero length; empty streams
  // therefore cost no cycles. Falls through to DRAIN when none is left.
  function automatic state_t next_stream(input logic [3:0] live, input int first);
    state_t s;
    s = S_DRAIN;
    for (int i = 3; i >= 0; i--)
      if (i >= first && live[i]) s = state_t'(4'(int'(S_IA_ADDR) + i));
    return s;
  endfunction

endpackage

// File: rtl/pe_csc_stream_loader_if.sv
// Source-buffer read ports and PE-side write/control signals of one loader.
// master = loader, slave = buffers + PE.
interface pe_csc_stream_loader_if
  import pe_csc_stream_loader_pkg::*;
#(
  parameter int MEM_AW = 8
);
  logic                 ia_addr_rd_en, ia_data_rd_en, w_addr_rd_en, w_data_rd_en;
  logic [MEM_AW-1:0]    ia_addr_rd_addr, ia_data_rd_addr, w_addr_rd_addr, w_data_rd_addr;
  logic [IA_ADDR_W-1:0] ia_addr_rd_data;
  logic [IA_DATA_W-1:0] ia_data_rd_data;
  logic [W_ADDR_W-1:0]  w_addr_rd_data;
  logic [W_DATA_W-1:0]  w_data_rd_data;

  logic                 iact_address_in_valid, iact_data_in_valid;
  logic                 weight_address_in_valid, weight_data_in_valid;
  logic [IA_ADDR_W-1:0] iact_address_in;
  logic [IA_DATA_W-1:0] iact_data_in;
  logic [W_ADDR_W-1:0]  weight_address_in;
  logic [W_DATA_W-1:0]  weight_data_in;

  logic iact_write_fin_clear, weight_write_fin_clear, all_write_fin;
  logic do_load_en, cal_fin;

  modport master (
    output ia_addr_rd_en, ia_data_rd_en, w_addr_rd_en, w_data_rd_en,
    output ia_addr_rd_addr, ia_data_rd_addr, w_addr_rd_addr, w_data_rd_addr,
    input  ia_addr_rd_data, ia_data_rd_data, w_addr_rd_data, w_data_rd_data,
    output iact_address_in_valid, iact_data_in_valid, weight_address_in_valid, weight_data_in_valid,
    output iact_address_in, iact_data_in, weight_address_in, weight_data_in,
    output iact_write_fin_clear, weight_write_fin_clear, do_load_en,
    input  all_write_fin, cal_fin
  );

  modport slave (
    input  ia_addr_rd_en, ia_data_rd_en, w_addr_rd_en, w_data_rd_en,
    input  ia_addr_rd_addr, ia_data_rd_addr, w_addr_rd_addr, w_data_rd_addr,
    output ia_addr_rd_data, ia_data_rd_data, w_addr_rd_data, w_data_rd_data,
    input  iact_address_in_valid, iact_data_in_valid, weight_address_in_valid, weight_data_in_valid,
    input  iact_address_in, iact_data_in, weight_address_in, weight_data_in,
    input  iact_write_fin_clear, weight_write_fin_clear, do_load_en,
    output all_write_fin, cal_fin
  );
endinterface

// File: rtl/pe_csc_stream_loader_csc_rd_stream.sv
// One CSC read stream: reads base..base+len-1 while active and presents each
// returned word to the PE one cycle later with its own valid.
module pe_csc_stream_loader_csc_rd_stream #(
  parameter int MEM_AW = 8,
  parameter int LEN_W  = 9,
  parameter int DW     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              active,
  input  logic [MEM_AW-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              rd_en,
  output logic [MEM_AW-1:0] rd_addr,
  input  logic [DW-1:0]     rd_data,
  output logic              last,
  output logic              valid,
  output logic [DW-1:0]     data
);
  logic [LEN_W-1:0] cnt;

  assign rd_en   = active;
  // Truncation makes base + k wrap modulo 2^MEM_AW.
  assign rd_addr = base + MEM_AW'(cnt);
  assign last    = active && (cnt == len - LEN_W'(1));
  // Gated so a reset or idle cycle never shows stale buffer data to the PE.
  assign data    = valid ? rd_data : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= active;
      if (last)        cnt <= '0;
      else if (active) cnt <= cnt + LEN_W'(1);
    end
  end
endmodule

// File: rtl/pe_csc_stream_loader.sv
// Per-PE feeder: clears write_fin, streams iact/weight CSC vectors into the PE,
// then runs the load / calculate handshake.
module pe_csc_stream_loader
  import pe_csc_stream_loader_pkg::*;
#(
  parameter int MEM_AW = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              iact_reuse,
  input  logic [MEM_AW-1:0] iact_base,
  input  logic [MEM_AW-1:0] weight_base,
  input  logic [LEN_W-1:0]  ia_addr_len,
  input  logic [LEN_W-1:0]  ia_data_len,
  input  logic [LEN_W-1:0]  w_addr_len,
  input  logic [LEN_W-1:0]  w_data_len,
  output logic              busy,
  output logic              done,
  pe_csc_stream_loader_if.master bus
);
  state_t                      state, state_next;
  logic                        reuse_q;
  logic [MEM_AW-1:0]           ia_base_q, w_base_q;
  logic [3:0][LEN_W-1:0]       len_q;
  logic [3:0]                  active, last, live;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      reuse_q   <= 1'b0;
      ia_base_q <= '0;
      w_base_q  <= '0;
      len_q     <= '0;
    end else begin
      state <= state_next;
      done  <= (state == S_WAIT_CAL) && bus.cal_fin;
      if (state == S_IDLE && start) begin
        reuse_q   <= iact_reuse;
        ia_base_q <= iact_base;
        w_base_q  <= weight_base;
        len_q     <= {w_data_len, w_addr_len, ia_data_len, ia_addr_len};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) live[i] = (len_q[i] != '0);
  end

  // NOTE: next state defaults to the current state first, so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_CLR_W;
      // Weight clear goes first: the PE only honours it while all_write_fin is still high.
      S_CLR_W:    state_next = reuse_q ? next_stream(live, int'(W_ADDR)) : S_CLR_I;
      S_CLR_I:    state_next = next_stream(live, int'(IA_ADDR));
      S_IA_ADDR:  if (last[IA_ADDR]) state_next = next_stream(live, int'(IA_DATA));
      S_IA_DATA:  if (last[IA_DATA]) state_next = next_stream(live, int'(W_ADDR));
      S_W_ADDR:   if (last[W_ADDR])  state_next = next_stream(live, int'(W_DATA));
      S_W_DATA:   if (last[W_DATA])  state_next = next_stream(live, 4);
      S_DRAIN:    state_next = S_WAIT_FIN;
      S_WAIT_FIN: if (bus.all_write_fin) state_next = S_LOAD;
      S_LOAD:     state_next = S_WAIT_CAL;
      S_WAIT_CAL: if (bus.cal_fin) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  assign active = {state == S_W_DATA, state == S_W_ADDR, state == S_IA_DATA, state == S_IA_ADDR};
  assign busy                       = (state != S_IDLE);
  assign bus.weight_write_fin_clear = (state == S_CLR_W);
  assign bus.iact_write_fin_clear   = (state == S_CLR_I);
  assign bus.do_load_en             = (state == S_LOAD);

  pe_csc_stream_loader_csc_rd_stream #(.MEM_AW(MEM_AW), .LEN_W(LEN_W), .DW(IA_ADDR_W)) u_ia_addr (
    .clock, .reset, .active(active[IA_ADDR]), .base(ia_base_q), .len(len_q[IA_ADDR]),
    .rd_en(bus.ia_addr_rd_en), .rd_addr(bus.ia_addr_rd_addr), .rd_data(bus.ia_addr_rd_data),
    .last(last[IA_ADDR]), .valid(bus.iact_address_in_valid), .data(bus.iact_address_in));

  pe_csc_stream_loader_csc_rd_stream #(.MEM_AW(MEM_AW), .LEN_W(LEN_W), .DW(IA_DATA_W)) u_ia_data (
    .clock, .reset, .active(active[IA_DATA]), .base(ia_base_q), .len(len_q[IA_DATA]),
    .rd_en(bus.ia_data_rd_en), .rd_addr(bus.ia_data_rd_addr), .rd_data(bus.ia_data_rd_data),
    .last(last[IA_DATA]), .valid(bus.iact_data_in_valid), .data(bus.iact_data_in));

  pe_csc_stream_loader_csc_rd_stream #(.MEM_AW(MEM_AW), .LEN_W(LEN_W), .DW(W_ADDR_W)) u_w_addr (
    .clock, .reset, .active(active[W_ADDR]), .base(w_base_q), .len(len_q[W_ADDR]),
    .rd_en(bus.w_addr_rd_en), .rd_addr(bus.w_addr_rd_addr), .rd_data(bus.w_addr_rd_data),
    .last(last[W_ADDR]), .valid(bus.weight_address_in_valid), .data(bus.weight_address_in));

  pe_csc_stream_loader_csc_rd_stream #(.MEM_AW(MEM_AW), .LEN_W(LEN_W), .DW(W_DATA_W)) u_w_data (
    .clock, .reset, .active(active[W_DATA]), .base(w_base_q), .len(len_q[W_DATA]),
    .rd_en(bus.w_data_rd_en), .rd_addr(bus.w_data_rd_addr), .rd_data(bus.w_data_rd_data),
    .last(last[W_DATA]), .valid(bus.weight_data_in_valid), .data(bus.weight_data_in));
endmodule

// File: tb/tb_pe_csc_stream_loader.sv
// Scoreboard bench for pe_csc_stream_loader: buffer models answer reads, a reference
// model queues the expected PE words, and a negedge monitor pops and compares them.
module tb_pe_csc_stream_loader;
  import pe_csc_stream_loader_pkg::*;

  logic       clock = 1'b0, reset = 1'b1, start = 1'b0, iact_reuse = 1'b0;
  logic [7:0] iact_base = '0, weight_base = '0;
  logic [8:0] ia_addr_len = '0, ia_data_len = '0, w_addr_len = '0, w_data_len = '0;
  logic       busy, done;

  pe_csc_stream_loader_if #(.MEM_AW(8)) bus();

  pe_csc_stream_loader #(.MEM_AW(8), .LEN_W(9)) dut (
    .clock(clock), .reset(reset), .start(start), .iact_reuse(iact_reuse),
    .iact_base(iact_base), .weight_base(weight_base),
    .ia_addr_len(ia_addr_len), .ia_data_len(ia_data_len),
    .w_addr_len(w_addr_len), .w_data_len(w_data_len),
    .busy(busy), .done(done), .bus(bus));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Source buffers: the low address bits are embedded in every word so a wrong
  // read address shows up as wrong data.
  logic [IA_ADDR_W-1:0] m_ia_addr [256];
  logic [IA_DATA_W-1:0] m_ia_data [256];
  logic [W_ADDR_W-1:0]  m_w_addr  [256];
  logic [W_DATA_W-1:0]  m_w_data  [256];

  always @(posedge clock) begin
    if (bus.ia_addr_rd_en) bus.ia_addr_rd_data <= m_ia_addr[bus.ia_addr_rd_addr];
    if (bus.ia_data_rd_en) bus.ia_data_rd_data <= m_ia_data[bus.ia_data_rd_addr];
    if (bus.w_addr_rd_en)  bus.w_addr_rd_data  <= m_w_addr[bus.w_addr_rd_addr];
    if (bus.w_data_rd_en)  bus.w_data_rd_data  <= m_w_data[bus.w_data_rd_addr];
  end

  typedef struct { int sid; int data; } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  int nvalid, first_v, last_v, wclr_n, wclr_c, iclr_n, iclr_c, load_n, load_c, done_n, done_c, busy_fall;
  bit prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic any_out();
    return |{bus.ia_addr_rd_en, bus.ia_data_rd_en, bus.w_addr_rd_en, bus.w_data_rd_en,
             bus.ia_addr_rd_addr, bus.ia_data_rd_addr, bus.w_addr_rd_addr, bus.w_data_rd_addr,
             bus.iact_address_in_valid, bus.iact_data_in_valid,
             bus.weight_address_in_valid, bus.weight_data_in_valid,
             bus.iact_address_in, bus.iact_data_in, bus.weight_address_in, bus.weight_data_in,
             bus.iact_write_fin_clear, bus.weight_write_fin_clear, bus.do_load_en, busy, done};
  endfunction

  function automatic int model_word(input int sid, input int addr);
    case (sid)
      0:       return int'(m_ia_addr[addr & 255]);
      1:       return int'(m_ia_data[addr & 255]);
      2:       return int'(m_w_addr[addr & 255]);
      default: return int'(m_w_data[addr & 255]);
    endcase
  endfunction

  // Monitor: every PE-side valid pops one expected word.
  initial forever begin : monitor
    logic [3:0] v;
    int sid, act;
    exp_t e;
    @(negedge clock);
    if (!reset) begin
      v = {bus.weight_data_in_valid, bus.weight_address_in_valid,
           bus.iact_data_in_valid, bus.iact_address_in_valid};
      if (v != 4'b0) begin
        check("valid_onehot", 64'($countones(v)), 64'd1);
        if (v[0])      begin sid = 0; act = int'(bus.iact_address_in);   end
        else if (v[1]) begin sid = 1; act = int'(bus.iact_data_in);      end
        else if (v[2]) begin sid = 2; act = int'(bus.weight_address_in); end
        else           begin sid = 3; act = int'(bus.weight_data_in);    end
        check("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_stream", 64'(sid), 64'(e.sid));
          check("sb_data", 64'(act), 64'(e.data));
        end
        nvalid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (bus.weight_write_fin_clear) begin wclr_n++; wclr_c = cyc; end
      if (bus.iact_write_fin_clear)   begin iclr_n++; iclr_c = cyc; end
      if (bus.do_load_en)             begin load_n++; load_c = cyc; end
      if (done)                       begin done_n++; done_c = cyc; end
      if (prev_busy && !busy) busy_fall = cyc;
    end
    prev_busy = busy;
  end

  task automatic clear_stats();
    nvalid = 0; first_v = -1; last_v = -1;
    wclr_n = 0; wclr_c = -1; iclr_n = 0; iclr_c = -1;
    load_n = 0; load_c = -1; done_n = 0; done_c = -1; busy_fall = -1;
  endtask

  // Reference model: streams in order, iact skipped on reuse, word k at base + k mod 256.
  task automatic issue(input bit reuse, input int ib, input int wb, input int l0, input int l1,
                       input int l2, input int l3, output int n, output int s);
    int lens[4];
    lens = '{l0, l1, l2, l3};
    n = 0;
    for (int sid = 0; sid < 4; sid++) begin
      if (!(reuse && sid < 2))
        for (int k = 0; k < lens[sid]; k++) begin
          q.push_back('{sid, model_word(sid, (sid < 2 ? ib : wb) + k)});
          n++;
        end
    end
    clear_stats();
    iact_reuse = reuse; iact_base = 8'(ib); weight_base = 8'(wb);
    ia_addr_len = 9'(l0); ia_data_len = 9'(l1); w_addr_len = 9'(l2); w_data_len = 9'(l3);
    start = 1'b1;
    s = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run(input bit reuse, input int ib, input int wb, input int l0, input int l1,
                     input int l2, input int l3, input bit spur_start, input bit early_cal);
    int n, s, f, c, wait_n;
    issue(reuse, ib, wb, l0, l1, l2, l3, n, s);
    wait_n = (n + 4 > 18) ? n + 4 : 18;
    for (int i = 0; i < wait_n; i++) begin
      if (spur_start && i == 1) begin
        start = 1'b1; iact_reuse = ~reuse; iact_base = 8'h99; weight_base = 8'h33; w_addr_len = 9'd7;
      end else start = 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    bus.all_write_fin = 1'b1; f = cyc;
    @(negedge clock);
    bus.all_write_fin = 1'b0;
    bus.cal_fin = early_cal;
    @(negedge clock);
    bus.cal_fin = 1'b0;
    repeat (5) @(negedge clock);
    bus.cal_fin = 1'b1; c = cyc;
    @(negedge clock);
    bus.cal_fin = 1'b0;
    @(negedge clock);
    check("w_clear_count", 64'(wclr_n), 64'd1);
    check("w_clear_cycle", 64'(wclr_c), 64'(s + 1));
    check("i_clear_count", 64'(iclr_n), reuse ? 64'd0 : 64'd1);
    if (!reuse) check("i_clear_cycle", 64'(iclr_c), 64'(s + 2));
    check("valid_count", 64'(nvalid), 64'(n));
    check("sb_drained", 64'(q.size()), 64'd0);
    if (n > 0) begin
      check("first_valid_cycle", 64'(first_v), 64'(s + (reuse ? 3 : 4)));
      check("valids_contiguous", 64'(last_v - first_v + 1), 64'(n));
    end
    check("load_count", 64'(load_n), 64'd1);
    check("load_cycle", 64'(load_c), 64'(f + 1));
    check("done_count", 64'(done_n), 64'd1);
    check("done_cycle", 64'(done_c), 64'(c + 1));
    check("busy_fall_cycle", 64'(busy_fall), 64'(c + 1));
    check("idle_after_done", 64'(busy), 64'd0);
    q.delete();
  endtask

  task automatic reset_mid();
    int n, s;
    bit found;
    issue(1'b0, 'h10, 'h40, 3, 5, 2, 4, n, s);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.w_addr_rd_en) found = 1'b1;
      else @(negedge clock);
    end
    check("reached_w_addr", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_reset_outputs_zero", 64'(any_out()), 64'd0);
    check("mid_reset_idle", 64'(busy), 64'd0);
    q.delete();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("post_reset_still_idle", 64'(any_out()), 64'd0);
    run(1'b0, 'h10, 'h40, 3, 5, 2, 4, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) begin
      m_ia_addr[a] = 8'(a);
      m_ia_data[a] = {5'($urandom), 8'(a)};
      m_w_addr[a]  = 7'(a);
      m_w_data[a]  = {4'($urandom), 8'(a)};
    end
    bus.all_write_fin = 1'b0;
    bus.cal_fin = 1'b0;
    clear_stats();
    repeat (3) @(negedge clock);
    check("reset_outputs_zero", 64'(any_out()), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_outputs_zero", 64'(any_out()), 64'd0);

    run(1'b0, 'h10, 'h40, 3, 5, 2, 4, 1'b0, 1'b1);   // full load, early cal_fin ignored
    run(1'b1, 'h10, 'h40, 3, 5, 2, 4, 1'b0, 1'b0);   // iact reuse
    run(1'b0, 'h20, 'h60, 2, 0, 2, 2, 1'b0, 1'b0);   // empty iact data stream
    reset_mid();
    run(1'b0, 'h05, 'hFE, 1, 1, 4, 2, 1'b1, 1'b0);   // weight address wrap, start while busy
    run(1'b1, 'h00, 'h00, 0, 0, 0, 0, 1'b0, 1'b0);   // nothing to stream
    for (int r = 0; r < 8; r++)
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
          int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
